// File: rtl/ahb_apb_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_apb_ctrl_if
// Signal bundle between an AHB master/APB slave environment and the
// ahb_apb_ctrl sequencing controller.
//   master modport : the environment side. It drives the AHB request and
//                    the APB slave responses (prdata/pready), and observes
//                    the bridge outputs.
//   slave modport  : the controller side. It receives the AHB request and
//                    the APB responses, and drives hrdata/hreadyout/hresp and
//                    the APB request (paddr/pwdata/pwrite/psel/penable).
// NSLV sets the width of the one-hot psel vector.
// ---------------------------------------------------------------------------
interface ahb_apb_ctrl_if #(
  parameter int NSLV = 4
);
  // AHB side
  logic            hwrite;
  logic [1:0]      htrans;
  logic [2:0]      hsize;
  logic [2:0]      hburst;
  logic            hreadyin;
  logic [31:0]     haddr;
  logic [31:0]     hwdata;
  logic [31:0]     hrdata;
  logic            hreadyout;
  logic [1:0]      hresp;
  // APB side
  logic [31:0]     paddr;
  logic [31:0]     pwdata;
  logic            pwrite;
  logic [NSLV-1:0] psel;
  logic            penable;
  logic [31:0]     prdata;
  logic            pready;

  modport master (
    output hwrite, htrans, hsize, hburst, hreadyin, haddr, hwdata,
    output prdata, pready,
    input  hrdata, hreadyout, hresp,
    input  paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    input  hwrite, htrans, hsize, hburst, hreadyin, haddr, hwdata,
    input  prdata, pready,
    output hrdata, hreadyout, hresp,
    output paddr, pwdata, pwrite, psel, penable
  );
endinterface

// File: rtl/ahb_apb_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_apb_ctrl
// Sequencing controller for an AHB-to-APB bridge. Each accepted single AHB
// transfer becomes one APB SETUP/ACCESS cycle on one of NSLV selects; the AHB
// master is stalled via hreadyout while the APB side is busy. Undecoded
// addresses, sizes above a word and APB timeouts get a two-cycle ERROR.
//
// Ports:
//   clk     : clock, all logic on posedge
//   resetn  : synchronous reset, active HIGH (the name is historical)
//   bus     : ahb_apb_ctrl_if.slave
//             in : hwrite htrans hsize hburst hreadyin haddr hwdata prdata pready
//             out: hrdata hreadyout hresp paddr pwdata pwrite psel penable
//
// Parameters:
//   NSLV      : number of APB slaves (power of 2, <= 16)
//   SLV_SHIFT : log2 of the per-slave address window
//   BASE      : bridge base address, aligned to NSLV << SLV_SHIFT
//   TMO       : max ACCESS cycles waiting for pready (0 = no timeout)
//
// hburst is not used: every beat is treated as an independent transfer.
// ---------------------------------------------------------------------------
module ahb_apb_ctrl #(
  parameter int          NSLV      = 4,
  parameter int          SLV_SHIFT = 12,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          TMO       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  ahb_apb_ctrl_if.slave    bus
);

  localparam int IW = $clog2(NSLV);
  localparam int XW = (IW > 0) ? IW : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WWAIT,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state_reg;
  logic [31:0]     addr_reg;
  logic            wr_reg;
  logic [XW-1:0]   idx_reg;
  logic [CW-1:0]   cnt_reg;

  logic [31:0]     hrdata_reg;
  logic            hreadyout_reg;
  logic [1:0]      hresp_reg;
  logic [31:0]     paddr_reg;
  logic [31:0]     pwdata_reg;
  logic            pwrite_reg;
  logic [NSLV-1:0] psel_reg;
  logic            penable_reg;

  logic            accept;
  logic            hit;
  logic            req_err;
  logic [XW-1:0]   idx_next;
  logic [NSLV-1:0] sel_new;   // decoded from the live address (read goes straight to SETUP)
  logic [NSLV-1:0] sel_held;  // decoded from the latched index (write passes through WWAIT)

  always_comb begin
    accept   = bus.hreadyin && bus.htrans[1];
    hit      = (bus.haddr >> (SLV_SHIFT + IW)) == (BASE >> (SLV_SHIFT + IW));
    req_err  = !hit || (bus.hsize > 3'd2);
    idx_next = XW'((bus.haddr >> SLV_SHIFT) & (NSLV - 1));
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_sel
      assign sel_new[gi]  = (idx_next == XW'(gi));
      assign sel_held[gi] = (idx_reg  == XW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      wr_reg        <= 1'b0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      hrdata_reg    <= '0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 2'b00;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pwrite_reg    <= 1'b0;
      psel_reg      <= '0;
      penable_reg   <= 1'b0;
    end else begin
      case (state_reg)
        // IDLE, DONE and ERR2 all present hreadyout=1, so each can take the
        // next address phase; this is what makes back-to-back transfers work.
        S_IDLE, S_DONE, S_ERR2: begin
          if (accept) begin
            addr_reg      <= bus.haddr;
            wr_reg        <= bus.hwrite;
            idx_reg       <= idx_next;
            hreadyout_reg <= 1'b0;
            if (req_err) begin
              state_reg <= S_ERR1;
              hresp_reg <= 2'b01;
            end else if (bus.hwrite) begin
              state_reg <= S_WWAIT;
              hresp_reg <= 2'b00;
            end else begin
              state_reg  <= S_SETUP;
              hresp_reg  <= 2'b00;
              psel_reg   <= sel_new;
              paddr_reg  <= bus.haddr;
              pwrite_reg <= 1'b0;
              cnt_reg    <= '0;
            end
          end else begin
            state_reg     <= S_IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 2'b00;
          end
        end

        // hwdata belongs to the cycle after the address phase.
        S_WWAIT: begin
          state_reg  <= S_SETUP;
          pwdata_reg <= bus.hwdata;
          psel_reg   <= sel_held;
          paddr_reg  <= addr_reg;
          pwrite_reg <= 1'b1;
          cnt_reg    <= '0;
        end

        S_SETUP: begin
          state_reg   <= S_ACCESS;
          penable_reg <= 1'b1;
        end

        S_ACCESS: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus.pready) begin
            state_reg     <= S_DONE;
            psel_reg      <= '0;
            penable_reg   <= 1'b0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 2'b00;
            if (!wr_reg) begin
              hrdata_reg <= bus.prdata;
            end
          end else if (TMO != 0 && cnt_reg == TMO_LAST) begin
            // Slave never answered: abandon the APB cycle and report ERROR.
            state_reg   <= S_ERR1;
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            hresp_reg   <= 2'b01;
          end
        end

        S_ERR1: begin
          state_reg     <= S_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 2'b01;
        end

        default: begin
          state_reg     <= S_IDLE;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 2'b00;
          psel_reg      <= '0;
          penable_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hrdata    = hrdata_reg;
  assign bus.hreadyout = hreadyout_reg;
  assign bus.hresp     = hresp_reg;
  assign bus.paddr     = paddr_reg;
  assign bus.pwdata    = pwdata_reg;
  assign bus.pwrite    = pwrite_reg;
  assign bus.psel      = psel_reg;
  assign bus.penable   = penable_reg;

endmodule

// File: tb/tb_ahb_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_ctrl
// Directed bench for ahb_apb_ctrl with NSLV=4, SLV_SHIFT=12, BASE=0x8000_0000,
// TMO=16. Inputs change #1 after the rising edge, and outputs are sampled at
// the same point, so every sample shows the state entered on the last edge.
// ---------------------------------------------------------------------------
module tb_ahb_apb_ctrl;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  ahb_apb_ctrl_if #(.NSLV(4)) bus ();

  ahb_apb_ctrl #(
    .NSLV      (4),
    .SLV_SHIFT (12),
    .BASE      (32'h8000_0000),
    .TMO       (16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.hwrite   = 1'b0;
    bus.htrans   = 2'b00;
    bus.hsize    = 3'd2;
    bus.hburst   = 3'd0;
    bus.hreadyin = 1'b1;
    bus.haddr    = 32'h0;
    bus.hwdata   = 32'h0;
    bus.prdata   = 32'h0;
    bus.pready   = 1'b0;
  endtask

  task automatic test_reset();
    bus_idle();
    resetn = 1'b1;
    tick();
    tick();
    total++; if (bus.hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%b want=1", bus.hreadyout); end
    total++; if (bus.hresp !== 2'b00) begin bad++; $display("FAIL rst_hresp got=%b want=00", bus.hresp); end
    total++; if (bus.psel !== 4'b0000) begin bad++; $display("FAIL rst_psel got=%b want=0000", bus.psel); end
    total++; if (bus.penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b want=0", bus.penable); end
    total++; if (bus.hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h want=0", bus.hrdata); end
    total++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.pwrite !== 1'b0) begin bad++; $display("FAIL rst_apb got paddr=%h pwdata=%h pwrite=%b want all 0", bus.paddr, bus.pwdata, bus.pwrite); end
    resetn = 1'b0;
    tick();
    $display("txn reset: outputs at reset values");
  endtask

  task automatic test_read();
    bus.haddr  = 32'h8000_1004;
    bus.hwrite = 1'b0;
    bus.htrans = 2'b10;
    bus.hsize  = 3'd2;
    bus.prdata = 32'hDEAD_BEEF;
    bus.pready = 1'b1;
    total++; if (bus.hreadyout !== 1'b1) begin bad++; $display("FAIL rd_addr_ready got=%b want=1", bus.hreadyout); end
    tick(); // SETUP
    bus.htrans = 2'b00;
    total++; if (bus.psel !== 4'b0010 || bus.penable !== 1'b0) begin bad++; $display("FAIL rd_setup got psel=%b pen=%b want 0010/0", bus.psel, bus.penable); end
    total++; if (bus.paddr !== 32'h8000_1004 || bus.pwrite !== 1'b0) begin bad++; $display("FAIL rd_paddr got=%h pwrite=%b want 80001004/0", bus.paddr, bus.pwrite); end
    total++; if (bus.hreadyout !== 1'b0) begin bad++; $display("FAIL rd_stall1 got=%b want=0", bus.hreadyout); end
    tick(); // ACCESS
    total++; if (bus.psel !== 4'b0010 || bus.penable !== 1'b1 || bus.hreadyout !== 1'b0) begin bad++; $display("FAIL rd_access got psel=%b pen=%b rdy=%b want 0010/1/0", bus.psel, bus.penable, bus.hreadyout); end
    tick(); // DONE
    total++; if (bus.hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hrdata got=%h want=deadbeef", bus.hrdata); end
    total++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00) begin bad++; $display("FAIL rd_done got rdy=%b resp=%b want 1/00", bus.hreadyout, bus.hresp); end
    total++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin bad++; $display("FAIL rd_release got psel=%b pen=%b want 0000/0", bus.psel, bus.penable); end
    bus.pready = 1'b0;
    tick(); // IDLE
    $display("txn read 80001004 -> %h", bus.hrdata);
  endtask

  task automatic test_write_wait();
    int stalls;
    int acc;
    bus.haddr  = 32'h8000_3000;
    bus.hwrite = 1'b1;
    bus.htrans = 2'b10;
    bus.hsize  = 3'd2;
    bus.pready = 1'b0;
    tick(); // WWAIT
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hwdata = 32'h1234_5678;
    stalls = 0;
    acc    = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.hreadyout !== 1'b0) break;
      stalls++;
      if (bus.psel !== 4'b0000) begin
        if (bus.penable === 1'b1) acc++;
        total++; if (bus.psel !== 4'b1000 || bus.pwdata !== 32'h1234_5678 || bus.paddr !== 32'h8000_3000 || bus.pwrite !== 1'b1) begin bad++; $display("FAIL wr_stable got psel=%b pwdata=%h paddr=%h pwrite=%b", bus.psel, bus.pwdata, bus.paddr, bus.pwrite); end
      end
      // slave answers in the third ACCESS cycle
      bus.pready = (acc == 3);
      tick();
    end
    bus.pready = 1'b0;
    total++; if (stalls !== 5) begin bad++; $display("FAIL wr_stalls got=%0d want=5", stalls); end
    total++; if (acc !== 3) begin bad++; $display("FAIL wr_access got=%0d want=3", acc); end
    total++; if (bus.hresp !== 2'b00 || bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin bad++; $display("FAIL wr_done got resp=%b psel=%b pen=%b", bus.hresp, bus.psel, bus.penable); end
    total++; if (bus.hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hrdata_hold got=%h want=deadbeef", bus.hrdata); end
    tick();
    $display("txn write 80003000 <- 12345678 stalls=%0d", stalls);
  endtask

  task automatic test_decode_err();
    bus.haddr  = 32'h9000_0000;
    bus.hwrite = 1'b0;
    bus.htrans = 2'b10;
    tick(); // ERR1
    bus.htrans = 2'b00;
    total++; if (bus.hreadyout !== 1'b0 || bus.hresp !== 2'b01 || bus.psel !== 4'b0000) begin bad++; $display("FAIL derr_err1 got rdy=%b resp=%b psel=%b want 0/01/0000", bus.hreadyout, bus.hresp, bus.psel); end
    tick(); // ERR2
    total++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b01 || bus.psel !== 4'b0000) begin bad++; $display("FAIL derr_err2 got rdy=%b resp=%b psel=%b want 1/01/0000", bus.hreadyout, bus.hresp, bus.psel); end
    // next transfer offered in ERR2
    bus.haddr  = 32'h8000_0010;
    bus.htrans = 2'b10;
    bus.prdata = 32'hCAFE_0001;
    bus.pready = 1'b1;
    tick(); // SETUP
    bus.htrans = 2'b00;
    total++; if (bus.psel !== 4'b0001 || bus.hresp !== 2'b00 || bus.paddr !== 32'h8000_0010) begin bad++; $display("FAIL derr_next got psel=%b resp=%b paddr=%h", bus.psel, bus.hresp, bus.paddr); end
    tick(); // ACCESS
    tick(); // DONE
    total++; if (bus.hrdata !== 32'hCAFE_0001 || bus.hreadyout !== 1'b1) begin bad++; $display("FAIL derr_next_data got=%h rdy=%b want cafe0001/1", bus.hrdata, bus.hreadyout); end
    bus.pready = 1'b0;
    tick();
    $display("txn read 90000000 -> ERROR, then read 80000010 -> %h", bus.hrdata);
  endtask

  task automatic test_size_err();
    bus.haddr  = 32'h8000_0000;
    bus.hwrite = 1'b1;
    bus.hsize  = 3'd3;
    bus.htrans = 2'b10;
    tick(); // ERR1
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd2;
    total++; if (bus.hreadyout !== 1'b0 || bus.hresp !== 2'b01 || bus.psel !== 4'b0000) begin bad++; $display("FAIL serr_err1 got rdy=%b resp=%b psel=%b", bus.hreadyout, bus.hresp, bus.psel); end
    tick(); // ERR2
    total++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b01 || bus.psel !== 4'b0000) begin bad++; $display("FAIL serr_err2 got rdy=%b resp=%b psel=%b", bus.hreadyout, bus.hresp, bus.psel); end
    tick(); // IDLE
    total++; if (bus.hresp !== 2'b00 || bus.psel !== 4'b0000 || bus.hreadyout !== 1'b1) begin bad++; $display("FAIL serr_idle got resp=%b psel=%b rdy=%b", bus.hresp, bus.psel, bus.hreadyout); end
    $display("txn write hsize=3 80000000 -> ERROR");
  endtask

  task automatic test_timeout();
    int acc;
    bus.haddr  = 32'h8000_2000;
    bus.hwrite = 1'b0;
    bus.htrans = 2'b10;
    bus.pready = 1'b0;
    tick(); // SETUP
    bus.htrans = 2'b00;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.penable === 1'b1) acc++;
      else break;
    end
    total++; if (acc !== 16) begin bad++; $display("FAIL tmo_cycles got=%0d want=16", acc); end
    total++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin bad++; $display("FAIL tmo_drop got psel=%b pen=%b", bus.psel, bus.penable); end
    total++; if (bus.hreadyout !== 1'b0 || bus.hresp !== 2'b01) begin bad++; $display("FAIL tmo_err1 got rdy=%b resp=%b want 0/01", bus.hreadyout, bus.hresp); end
    tick(); // ERR2
    total++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b01) begin bad++; $display("FAIL tmo_err2 got rdy=%b resp=%b want 1/01", bus.hreadyout, bus.hresp); end
    tick(); // IDLE
    total++; if (bus.hresp !== 2'b00) begin bad++; $display("FAIL tmo_idle got resp=%b want 00", bus.hresp); end
    $display("txn read 80002000 -> timeout after %0d ACCESS cycles", acc);
  endtask

  task automatic test_reset_mid();
    bus.haddr  = 32'h8000_1000;
    bus.hwrite = 1'b0;
    bus.htrans = 2'b10;
    bus.pready = 1'b0;
    tick(); // SETUP
    bus.htrans = 2'b00;
    tick(); // ACCESS 1
    tick(); // ACCESS 2
    total++; if (bus.penable !== 1'b1 || bus.psel !== 4'b0010) begin bad++; $display("FAIL mrst_pre got pen=%b psel=%b want 1/0010", bus.penable, bus.psel); end
    resetn = 1'b1;
    tick();
    total++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0 || bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00) begin bad++; $display("FAIL mrst_post got psel=%b pen=%b rdy=%b resp=%b", bus.psel, bus.penable, bus.hreadyout, bus.hresp); end
    resetn = 1'b0;
    tick();
    $display("txn read 80001000 aborted by reset");
  endtask

  task automatic test_back_to_back();
    bus.haddr  = 32'h8000_0008;
    bus.hwrite = 1'b0;
    bus.htrans = 2'b10;
    bus.prdata = 32'h1111_2222;
    bus.pready = 1'b1;
    tick(); // SETUP
    bus.htrans = 2'b00;
    tick(); // ACCESS
    tick(); // DONE
    total++; if (bus.hrdata !== 32'h1111_2222 || bus.hreadyout !== 1'b1) begin bad++; $display("FAIL b2b_rd got=%h rdy=%b want 11112222/1", bus.hrdata, bus.hreadyout); end
    // next address phase lands in DONE
    bus.haddr  = 32'h8000_2004;
    bus.hwrite = 1'b1;
    bus.htrans = 2'b10;
    bus.prdata = 32'hFFFF_FFFF;
    tick(); // WWAIT
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hwdata = 32'h55AA_33CC;
    total++; if (bus.hreadyout !== 1'b0 || bus.psel !== 4'b0000) begin bad++; $display("FAIL b2b_wwait got rdy=%b psel=%b want 0/0000", bus.hreadyout, bus.psel); end
    tick(); // SETUP
    total++; if (bus.psel !== 4'b0100 || bus.pwrite !== 1'b1 || bus.paddr !== 32'h8000_2004 || bus.pwdata !== 32'h55AA_33CC) begin bad++; $display("FAIL b2b_setup got psel=%b pwrite=%b paddr=%h pwdata=%h", bus.psel, bus.pwrite, bus.paddr, bus.pwdata); end
    tick(); // ACCESS
    tick(); // DONE
    total++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00 || bus.hrdata !== 32'h1111_2222) begin bad++; $display("FAIL b2b_wr_done got rdy=%b resp=%b hrdata=%h", bus.hreadyout, bus.hresp, bus.hrdata); end
    bus.pready = 1'b0;
    // BUSY does nothing
    bus.htrans = 2'b01;
    tick();
    tick();
    total++; if (bus.hreadyout !== 1'b1 || bus.psel !== 4'b0000 || bus.hresp !== 2'b00) begin bad++; $display("FAIL busy_noop got rdy=%b psel=%b resp=%b", bus.hreadyout, bus.psel, bus.hresp); end
    bus.htrans = 2'b00;
    tick();
    $display("txn read 80000008 -> %h, write 80002004 <- 55aa33cc back to back", bus.hrdata);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b1;
    bus_idle();
    test_reset();
    test_read();
    test_write_wait();
    test_decode_err();
    test_size_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
